// File: rtl/cv32e40x_wb_stage_if.sv
// -----------------------------------------------------------------------------
// cv32e40x_wb_stage_if
// Bundles the signals between the write-back stage and its neighbours:
//   EX -> WB handshake and instruction fields (ex_*, wb_ready_o)
//   LSU read response                         (lsu_*)
//   RF write / forwarding port and retire     (rf_*_wb_o, wb_valid_o, wb_err_o)
// Signal suffixes are given from the write-back stage's point of view.
//   slave  : used by the write-back stage itself
//   master : used by whatever drives EX/LSU and observes the RF port
// -----------------------------------------------------------------------------
interface cv32e40x_wb_stage_if #(
   parameter int AW = 5
);
   logic          ex_wb_valid_i;
   logic          wb_ready_o;
   logic          ex_rf_we_i;
   logic [AW-1:0] ex_rf_waddr_i;
   logic [31:0]   ex_rf_wdata_i;
   logic          ex_load_i;
   logic [1:0]    ex_lsu_size_i;
   logic          ex_lsu_sext_i;
   logic [1:0]    ex_lsu_offset_i;
   logic          lsu_rvalid_i;
   logic [31:0]   lsu_rdata_i;
   logic          lsu_err_i;
   logic          rf_we_wb_o;
   logic [AW-1:0] rf_waddr_wb_o;
   logic [31:0]   rf_wdata_wb_o;
   logic          wb_valid_o;
   logic          wb_err_o;

   modport slave (
      input  ex_wb_valid_i, ex_rf_we_i, ex_rf_waddr_i, ex_rf_wdata_i,
             ex_load_i, ex_lsu_size_i, ex_lsu_sext_i, ex_lsu_offset_i,
             lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
      output wb_ready_o, rf_we_wb_o, rf_waddr_wb_o, rf_wdata_wb_o,
             wb_valid_o, wb_err_o
   );

   modport master (
      output ex_wb_valid_i, ex_rf_we_i, ex_rf_waddr_i, ex_rf_wdata_i,
             ex_load_i, ex_lsu_size_i, ex_lsu_sext_i, ex_lsu_offset_i,
             lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
      input  wb_ready_o, rf_we_wb_o, rf_waddr_wb_o, rf_wdata_wb_o,
             wb_valid_o, wb_err_o
   );
endinterface

// File: rtl/cv32e40x_wb_stage.sv
// -----------------------------------------------------------------------------
// cv32e40x_wb_stage
// Write-back stage directly downstream of EX. Holds one retiring instruction.
// Loads wait for the LSU response, which is aligned/extended here; everything
// else writes its EX result. The RF write port doubles as the WB->ID forwarding
// source. EX is backpressured through wb_ready_o.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   wb   : cv32e40x_wb_stage_if.slave (EX handshake, LSU response, RF port)
// Parameters:
//   REGFILE_AW : register file address width (must match the interface AW)
//   BLOCK_X0   : 1 suppresses RF writes to x0
// -----------------------------------------------------------------------------
module cv32e40x_wb_stage #(
   parameter int REGFILE_AW = 5,
   parameter bit BLOCK_X0   = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   cv32e40x_wb_stage_if.slave  wb
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,   // no entry
      S_FULL = 2'd1,   // non-load entry, retires immediately
      S_WAIT = 2'd2    // load entry waiting for its LSU response
   } state_e;

   typedef struct packed {
      logic                  we;
      logic [REGFILE_AW-1:0] waddr;
      logic [31:0]           wdata;
      logic [1:0]            size;
      logic                  sext;
      logic [1:0]            offset;
   } entry_t;

   state_e state_q, state_d;
   entry_t entry_q, entry_d;

   logic        retire;
   logic        ready;
   logic        accept;
   logic        lsu_err;
   logic        x0_block;
   logic        rf_we;
   logic [31:0] shifted;
   logic [31:0] load_data;

   // ---------------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------------
   // A response is only meaningful in WAIT; in IDLE/FULL (including the cycle a
   // load is being accepted) it belongs to no entry and is ignored.
   assign retire  = (state_q == S_FULL) || ((state_q == S_WAIT) && wb.lsu_rvalid_i);
   assign ready   = (state_q == S_IDLE) || retire;
   assign accept  = wb.ex_wb_valid_i && ready;
   assign lsu_err = (state_q == S_WAIT) && wb.lsu_rvalid_i && wb.lsu_err_i;

   // ---------------------------------------------------------------------------
   // FSM: state register and captured entry
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         entry_q <= '0;
      end else begin
         state_q <= state_d;
         entry_q <= entry_d;
      end
   end

   always_comb begin
      state_d = state_q;
      entry_d = entry_q;
      // Accept wins over retire-to-IDLE so a retiring entry is replaced in the
      // same cycle without a bubble.
      if (accept) begin
         state_d        = wb.ex_load_i ? S_WAIT : S_FULL;
         entry_d.we     = wb.ex_rf_we_i;
         entry_d.waddr  = wb.ex_rf_waddr_i;
         entry_d.wdata  = wb.ex_rf_wdata_i;
         entry_d.size   = wb.ex_lsu_size_i;
         entry_d.sext   = wb.ex_lsu_sext_i;
         entry_d.offset = wb.ex_lsu_offset_i;
      end else if (retire) begin
         state_d = S_IDLE;
      end
   end

   // ---------------------------------------------------------------------------
   // Load alignment
   // ---------------------------------------------------------------------------
   // Bus word is shifted down by the byte offset with zero fill. Misaligned
   // half/word loads are split upstream, so no wrap-around is needed here.
   assign shifted = wb.lsu_rdata_i >> {entry_q.offset, 3'b000};

   always_comb begin
      load_data = shifted;
      case (entry_q.size)
         2'b00:   load_data = {{24{entry_q.sext & shifted[7]}},  shifted[7:0]};
         2'b01:   load_data = {{16{entry_q.sext & shifted[15]}}, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   // ---------------------------------------------------------------------------
   // RF write port / retire outputs
   // ---------------------------------------------------------------------------
   assign x0_block = BLOCK_X0 && (entry_q.waddr == '0);
   assign rf_we    = retire && entry_q.we && !lsu_err && !x0_block;

   assign wb.wb_ready_o    = ready;
   assign wb.wb_valid_o    = retire;
   assign wb.wb_err_o      = lsu_err;
   assign wb.rf_we_wb_o    = rf_we;
   assign wb.rf_waddr_wb_o = (state_q != S_IDLE) ? entry_q.waddr : '0;
   // Data is forced to zero whenever no write happens so forwarding consumers
   // never see stale values.
   assign wb.rf_wdata_wb_o = !rf_we                ? 32'h0     :
                             (state_q == S_WAIT)   ? load_data : entry_q.wdata;

endmodule

// File: tb/tb_cv32e40x_wb_stage.sv
module tb_cv32e40x_wb_stage;

   logic clk;
   logic rst;

   cv32e40x_wb_stage_if #(.AW(5)) bus();

   cv32e40x_wb_stage #(.REGFILE_AW(5), .BLOCK_X0(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   bit   stray_ok = 1'b0;
   int   m_state = 0;   // 0 idle, 1 full, 2 wait (for the stray-response check)

   // ------------------------------------------------------------------ monitor
   always @(negedge clk) begin
      if (!rst && bus.wb_valid_o) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL retire_unexpected: got wb_valid_o=1 waddr=%0d, required no retire",
                     bus.rf_waddr_wb_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({bus.rf_we_wb_o, bus.rf_waddr_wb_o, bus.rf_wdata_wb_o, bus.wb_err_o} !==
                {e.we, e.waddr, e.wdata, e.err}) begin
               n_err++;
               $display("FAIL retire: got we=%b waddr=%0d wdata=%h err=%b, required we=%b waddr=%0d wdata=%h err=%b",
                        bus.rf_we_wb_o, bus.rf_waddr_wb_o, bus.rf_wdata_wb_o, bus.wb_err_o,
                        e.we, e.waddr, e.wdata, e.err);
            end
         end
      end
   end

   // Occupancy tracker: LSU responses must only arrive for a waiting load.
   always @(posedge clk or posedge rst) begin
      if (rst) m_state <= 0;
      else begin
         logic ret, rdy;
         ret = (m_state == 1) || (m_state == 2 && bus.lsu_rvalid_i);
         rdy = (m_state == 0) || ret;
         if (bus.ex_wb_valid_i && rdy) m_state <= bus.ex_load_i ? 2 : 1;
         else if (ret)                 m_state <= 0;
      end
   end

   always @(negedge clk) begin
      if (!rst && bus.lsu_rvalid_i && m_state != 2 && !stray_ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL stray_rvalid: got lsu_rvalid_i=1 in state %0d, required only in wait", m_state);
      end
   end

   // ------------------------------------------------------------------ drivers
   task automatic drive_ex(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                           input logic load, input logic [1:0] size, input logic sext,
                           input logic [1:0] off);
      bus.ex_wb_valid_i   = 1'b1;
      bus.ex_rf_we_i      = we;
      bus.ex_rf_waddr_i   = waddr;
      bus.ex_rf_wdata_i   = wdata;
      bus.ex_load_i       = load;
      bus.ex_lsu_size_i   = size;
      bus.ex_lsu_sext_i   = sext;
      bus.ex_lsu_offset_i = off;
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 20 && sb.size() != 0; k++) begin
         @(negedge clk); #1;
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL %s_timeout: got %0d retires outstanding, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.rf_we_wb_o !== 1'b0)    begin n_err++; $display("FAIL reset_we: got %b, required 0", bus.rf_we_wb_o); end
      n_cmp++; if (bus.rf_waddr_wb_o !== 5'd0) begin n_err++; $display("FAIL reset_waddr: got %0d, required 0", bus.rf_waddr_wb_o); end
      n_cmp++; if (bus.rf_wdata_wb_o !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h, required 0", bus.rf_wdata_wb_o); end
      n_cmp++; if (bus.wb_valid_o !== 1'b0)    begin n_err++; $display("FAIL reset_valid: got %b, required 0", bus.wb_valid_o); end
      n_cmp++; if (bus.wb_err_o !== 1'b0)      begin n_err++; $display("FAIL reset_err: got %b, required 0", bus.wb_err_o); end
      n_cmp++; if (bus.wb_ready_o !== 1'b1)    begin n_err++; $display("FAIL reset_ready: got %b, required 1", bus.wb_ready_o); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_alu();
      @(posedge clk); #1;
      drive_ex(1'b1, 5'd5, 32'h1234_5678, 1'b0, 2'b10, 1'b0, 2'b00);
      sb.push_back('{1'b1, 5'd5, 32'h1234_5678, 1'b0});
      @(posedge clk); #1;
      bus.ex_wb_valid_i = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.wb_valid_o !== 1'b1) begin n_err++; $display("FAIL alu_valid: got %b, required 1", bus.wb_valid_o); end
      n_cmp++; if (bus.wb_ready_o !== 1'b1) begin n_err++; $display("FAIL alu_ready: got %b, required 1", bus.wb_ready_o); end
      wait_drain("alu");
   endtask

   task automatic test_load_align();
      logic [1:0]  sz  [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
      logic        sx  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [1:0]  of  [5] = '{2'd2, 2'd2, 2'd0, 2'd3, 2'd0};
      logic [31:0] rd  [5] = '{32'h0080_0000, 32'hBEEF_0000, 32'hCAFE_BABE, 32'h8F12_3456, 32'h1234_F00D};
      int          dly [5] = '{3, 1, 0, 2, 0};
      logic [31:0] ex  [5] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hCAFE_BABE, 32'h0000_008F, 32'hFFFF_F00D};
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         drive_ex(1'b1, 5'(10 + i), 32'hDEAD_0000, 1'b1, sz[i], sx[i], of[i]);
         sb.push_back('{1'b1, 5'(10 + i), ex[i], 1'b0});
         @(posedge clk); #1;
         bus.ex_wb_valid_i = 1'b0;
         for (int d = 0; d < dly[i]; d++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.wb_ready_o !== 1'b0) begin
               n_err++;
               $display("FAIL load%0d_wait_ready: got %b, required 0", i, bus.wb_ready_o);
            end
            @(posedge clk); #1;
         end
         bus.lsu_rvalid_i = 1'b1;
         bus.lsu_rdata_i  = rd[i];
         bus.lsu_err_i    = 1'b0;
         @(negedge clk);
         n_cmp++;
         if (bus.wb_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL load%0d_resp_ready: got %b, required 1", i, bus.wb_ready_o);
         end
         @(posedge clk); #1;
         bus.lsu_rvalid_i = 1'b0;
         bus.lsu_rdata_i  = 32'h0;
         wait_drain("load");
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         logic [31:0] d;
         d = $urandom;
         @(posedge clk); #1;
         drive_ex(1'b1, 5'(i + 1), d, 1'b0, 2'b10, 1'b0, 2'b00);
         sb.push_back('{1'b1, 5'(i + 1), d, 1'b0});
         @(negedge clk);
         n_cmp++;
         if (bus.wb_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready%0d: got %b, required 1", i, bus.wb_ready_o);
         end
         if (i > 0) begin
            n_cmp++;
            if (bus.wb_valid_o !== 1'b1) begin
               n_err++;
               $display("FAIL b2b_valid%0d: got %b, required 1", i, bus.wb_valid_o);
            end
         end
      end
      @(posedge clk); #1;
      bus.ex_wb_valid_i = 1'b0;
      wait_drain("b2b");
   endtask

   task automatic test_err_and_x0();
      // Load completing with a bus error in the cycle right after acceptance.
      @(posedge clk); #1;
      drive_ex(1'b1, 5'd9, 32'h0, 1'b1, 2'b10, 1'b0, 2'b00);
      sb.push_back('{1'b0, 5'd9, 32'h0, 1'b1});
      @(posedge clk); #1;
      bus.ex_wb_valid_i = 1'b0;
      bus.lsu_rvalid_i  = 1'b1;
      bus.lsu_rdata_i   = 32'hFFFF_FFFF;
      bus.lsu_err_i     = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.wb_err_o !== 1'b1)   begin n_err++; $display("FAIL err_flag: got %b, required 1", bus.wb_err_o); end
      n_cmp++; if (bus.rf_we_wb_o !== 1'b0) begin n_err++; $display("FAIL err_we: got %b, required 0", bus.rf_we_wb_o); end
      @(posedge clk); #1;
      bus.lsu_rvalid_i = 1'b0;
      bus.lsu_err_i    = 1'b0;
      bus.lsu_rdata_i  = 32'h0;
      wait_drain("err");
      // Write to x0 is suppressed but still retires; we=0 op likewise.
      @(posedge clk); #1;
      drive_ex(1'b1, 5'd0, 32'hAAAA_5555, 1'b0, 2'b10, 1'b0, 2'b00);
      sb.push_back('{1'b0, 5'd0, 32'h0, 1'b0});
      @(posedge clk); #1;
      drive_ex(1'b0, 5'd3, 32'h1111_2222, 1'b0, 2'b10, 1'b0, 2'b00);
      sb.push_back('{1'b0, 5'd3, 32'h0, 1'b0});
      @(negedge clk);
      n_cmp++; if (bus.rf_we_wb_o !== 1'b0) begin n_err++; $display("FAIL x0_we: got %b, required 0", bus.rf_we_wb_o); end
      @(posedge clk); #1;
      bus.ex_wb_valid_i = 1'b0;
      wait_drain("x0");
   endtask

   task automatic test_accept_cycle_response();
      // Response in the acceptance cycle must be ignored; the next one counts.
      @(posedge clk); #1;
      stray_ok = 1'b1;
      drive_ex(1'b1, 5'd20, 32'h0, 1'b1, 2'b00, 1'b0, 2'b00);
      bus.lsu_rvalid_i = 1'b1;
      bus.lsu_rdata_i  = 32'h0000_0055;
      sb.push_back('{1'b1, 5'd20, 32'h0000_00A7, 1'b0});
      @(posedge clk); #1;
      stray_ok = 1'b0;
      bus.ex_wb_valid_i = 1'b0;
      bus.lsu_rdata_i   = 32'h0000_00A7;
      @(posedge clk); #1;
      bus.lsu_rvalid_i = 1'b0;
      bus.lsu_rdata_i  = 32'h0;
      wait_drain("acc_resp");
   endtask

   task automatic test_reset_in_wait();
      @(posedge clk); #1;
      drive_ex(1'b1, 5'd12, 32'h0, 1'b1, 2'b10, 1'b0, 2'b00);
      @(posedge clk); #1;
      bus.ex_wb_valid_i = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.wb_ready_o !== 1'b0) begin n_err++; $display("FAIL rstw_pre_ready: got %b, required 0", bus.wb_ready_o); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (bus.wb_ready_o !== 1'b1)    begin n_err++; $display("FAIL rstw_ready: got %b, required 1", bus.wb_ready_o); end
      n_cmp++; if (bus.rf_waddr_wb_o !== 5'd0) begin n_err++; $display("FAIL rstw_waddr: got %0d, required 0", bus.rf_waddr_wb_o); end
      @(posedge clk); #1;
      rst = 1'b0;
      stray_ok = 1'b1;
      bus.lsu_rvalid_i = 1'b1;
      bus.lsu_rdata_i  = 32'h1111_1111;
      @(negedge clk);
      n_cmp++; if (bus.wb_valid_o !== 1'b0) begin n_err++; $display("FAIL rstw_valid: got %b, required 0", bus.wb_valid_o); end
      n_cmp++; if (bus.rf_we_wb_o !== 1'b0) begin n_err++; $display("FAIL rstw_we: got %b, required 0", bus.rf_we_wb_o); end
      n_cmp++; if (bus.wb_ready_o !== 1'b1) begin n_err++; $display("FAIL rstw_ready_post: got %b, required 1", bus.wb_ready_o); end
      @(posedge clk); #1;
      bus.lsu_rvalid_i = 1'b0;
      bus.lsu_rdata_i  = 32'h0;
      stray_ok = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      rst                 = 1'b1;
      bus.ex_wb_valid_i   = 1'b0;
      bus.ex_rf_we_i      = 1'b0;
      bus.ex_rf_waddr_i   = 5'd0;
      bus.ex_rf_wdata_i   = 32'h0;
      bus.ex_load_i       = 1'b0;
      bus.ex_lsu_size_i   = 2'b00;
      bus.ex_lsu_sext_i   = 1'b0;
      bus.ex_lsu_offset_i = 2'b00;
      bus.lsu_rvalid_i    = 1'b0;
      bus.lsu_rdata_i     = 32'h0;
      bus.lsu_err_i       = 1'b0;

      test_reset();
      test_alu();
      test_load_align();
      test_back_to_back();
      test_err_and_x0();
      test_accept_cycle_response();
      test_reset_in_wait();

      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL final_queue: got %0d outstanding, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
